sfx_arbiter: RTL and testbench

SFX_ARBITER -- requirements
Module: sfx_arbiter

---
 rtl/sfx_arbiter_if.sv | 22 ++
 rtl/sfx_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_sfx_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sfx_arbiter_if.sv
// Avalon-MM register port bundle shared by the sound-effect arbiter and its host.
// Latency: none of its own; read data timing is set by the slave.
// Backpressure: none, zero-wait-state bus with no waitrequest.
interface sfx_arbiter_if;
    logic        AVL_READ;
    logic        AVL_WRITE;
    logic        AVL_CS;
    logic [3:0]  AVL_BYTE_EN;
    logic [3:0]  AVL_ADDR;
    logic [31:0] AVL_WRITEDATA;
    logic [31:0] AVL_READDATA;

    modport master (
        output AVL_READ, AVL_WRITE, AVL_CS, AVL_BYTE_EN, AVL_ADDR, AVL_WRITEDATA,
        input  AVL_READDATA
    );

    modport slave (
        input  AVL_READ, AVL_WRITE, AVL_CS, AVL_BYTE_EN, AVL_ADDR, AVL_WRITEDATA,
        output AVL_READDATA
    );
endinterface

// File: rtl/sfx_arbiter.sv
// Four-channel priority sound-effect player: fetches ROM samples, emits one per lrclk frame.
// Latency: read data 1 CLK after select; first sample fetched 3 CLK after SELECT, emitted on next lrclk rise.
// Backpressure: none; lrclk paces output, lrclk rises during a ROM fetch are dropped.
module sfx_arbiter (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        lrclk,
    input  logic [3:0]  req,
    sfx_arbiter_if.slave avl,
    output logic [14:0] rom_addr,
    input  logic [7:0]  rom_q,
    output logic [7:0]  sample_out,
    output logic        sample_strobe,
    output logic        busy
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SELECT = 2'd1;
    localparam logic [1:0] S_LOAD   = 2'd2;
    localparam logic [1:0] S_WAIT   = 2'd3;

    logic [1:0]  state;
    logic [3:0]  enable;
    logic        mute;
    logic [14:0] base [4];
    logic [14:0] len  [4];
    logic [3:0]  pending;
    logic [1:0]  cur_ch;
    logic [14:0] count;
    logic [14:0] cur_len;
    logic [7:0]  sample_buf;
    logic [3:0]  req_q;
    logic        lrclk_q;
    logic        load_cnt;
    logic        upd;

    logic        wr_en;
    logic        rd_en;
    logic        lr_rise;
    logic        in_bank;
    logic [1:0]  reg_idx;
    logic [3:0]  req_set;
    logic [3:0]  trig_set;
    logic [3:0]  sel_clr;
    logic [1:0]  sel_idx;
    logic [3:0]  le_mask;
    logic [31:0] rd_mux;
    logic        unused_bits;

    assign wr_en   = avl.AVL_CS & avl.AVL_WRITE;
    assign rd_en   = avl.AVL_CS & avl.AVL_READ;
    assign lr_rise = lrclk & ~lrclk_q;
    // BASE/LEN bank lives at word addresses 4..11, two words per channel
    assign in_bank = (avl.AVL_ADDR[3:2] == 2'b01) || (avl.AVL_ADDR[3:2] == 2'b10);
    assign reg_idx = avl.AVL_ADDR[2:1] + 2'd2;
    assign req_set = req & ~req_q & enable;
    assign trig_set = (wr_en && avl.AVL_ADDR == 4'd1 && avl.AVL_BYTE_EN[0])
                      ? avl.AVL_WRITEDATA[3:0] : 4'b0000;
    // busy covers actual playback only; a zero-length select never raises it
    assign busy = (state == S_LOAD) || (state == S_WAIT);
    assign unused_bits = ^{avl.AVL_WRITEDATA[31:15], avl.AVL_BYTE_EN[3:2]};

    function automatic logic [14:0] merge15(input logic [14:0] old, input logic [31:0] wd,
                                            input logic [3:0] be);
        merge15 = {be[1] ? wd[14:8] : old[14:8], be[0] ? wd[7:0] : old[7:0]};
    endfunction

    // Lowest pending index wins; mask of channels at or above current priority
    always_comb begin
        sel_idx = 2'd0;
        if (pending[0])      sel_idx = 2'd0;
        else if (pending[1]) sel_idx = 2'd1;
        else if (pending[2]) sel_idx = 2'd2;
        else if (pending[3]) sel_idx = 2'd3;
        sel_clr = 4'b0000;
        if (state == S_SELECT && pending != 4'b0000) sel_clr[sel_idx] = 1'b1;
        case (cur_ch)
            2'd0:    le_mask = 4'b0001;
            2'd1:    le_mask = 4'b0011;
            2'd2:    le_mask = 4'b0111;
            default: le_mask = 4'b1111;
        endcase
    end

    // Register read mux; unmapped addresses and unused bits read zero
    always_comb begin
        rd_mux = 32'd0;
        case (avl.AVL_ADDR)
            4'd0: begin
                rd_mux[3:0] = enable;
                rd_mux[8]   = mute;
            end
            4'd2: begin
                rd_mux[3:0] = pending;
                rd_mux[5:4] = cur_ch;
                rd_mux[6]   = busy;
            end
            default: begin
                if (in_bank) rd_mux[14:0] = avl.AVL_ADDR[0] ? len[reg_idx] : base[reg_idx];
            end
        endcase
    end

    // Edge-detect history; reset also loads the live inputs so no false edge follows reset
    always_ff @(posedge CLK) begin
        req_q   <= req;
        lrclk_q <= lrclk;
    end

    // CTRL and per-channel BASE/LEN registers, byte-gated writes
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            enable <= 4'b0000;
            mute   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                base[i] <= 15'd0;
                len[i]  <= 15'd0;
            end
        end else if (wr_en) begin
            if (avl.AVL_ADDR == 4'd0) begin
                if (avl.AVL_BYTE_EN[0]) enable <= avl.AVL_WRITEDATA[3:0];
                if (avl.AVL_BYTE_EN[1]) mute   <= avl.AVL_WRITEDATA[8];
            end else if (in_bank) begin
                if (avl.AVL_ADDR[0])
                    len[reg_idx]  <= merge15(len[reg_idx], avl.AVL_WRITEDATA, avl.AVL_BYTE_EN);
                else
                    base[reg_idx] <= merge15(base[reg_idx], avl.AVL_WRITEDATA, avl.AVL_BYTE_EN);
            end
        end
    end

    // Pending set wins over the selection clear in the same cycle
    always_ff @(posedge CLK) begin
        if (!RESET) pending <= 4'b0000;
        else        pending <= (pending & ~sel_clr) | req_set | trig_set;
    end

    // Registered read data, held between reads
    always_ff @(posedge CLK) begin
        if (!RESET)     avl.AVL_READDATA <= 32'd0;
        else if (rd_en) avl.AVL_READDATA <= rd_mux;
    end

    // Playback FSM; a WAIT strobe is followed by one decision cycle (upd) so the last
    // sample is visible before sample_out is cleared on return to IDLE
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state         <= S_IDLE;
            cur_ch        <= 2'd0;
            count         <= 15'd0;
            cur_len       <= 15'd0;
            rom_addr      <= 15'd0;
            sample_buf    <= 8'd0;
            sample_out    <= 8'd0;
            sample_strobe <= 1'b0;
            load_cnt      <= 1'b0;
            upd           <= 1'b0;
        end else begin
            sample_strobe <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pending != 4'b0000) state <= S_SELECT;
                end
                S_SELECT: begin
                    if (pending == 4'b0000 || len[sel_idx] == 15'd0) begin
                        state      <= S_IDLE;
                        sample_out <= 8'd0;
                    end else begin
                        cur_ch   <= sel_idx;
                        rom_addr <= base[sel_idx];
                        cur_len  <= len[sel_idx];
                        count    <= 15'd0;
                        load_cnt <= 1'b0;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (load_cnt) begin
                        sample_buf <= rom_q;
                        upd        <= 1'b0;
                        state      <= S_WAIT;
                    end else begin
                        load_cnt <= 1'b1;
                    end
                end
                default: begin
                    if (upd) begin
                        upd <= 1'b0;
                        if (count == cur_len) begin
                            state      <= S_IDLE;
                            sample_out <= 8'd0;
                        end else if ((pending & le_mask) != 4'b0000) begin
                            state <= S_SELECT;
                        end else begin
                            rom_addr <= rom_addr + 15'd1;
                            load_cnt <= 1'b0;
                            state    <= S_LOAD;
                        end
                    end else if (lr_rise) begin
                        sample_out    <= mute ? 8'd0 : sample_buf;
                        sample_strobe <= 1'b1;
                        count         <= count + 15'd1;
                        upd           <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sfx_arbiter.sv
// Bench for sfx_arbiter: register access, priority, preemption, mute and reset scenarios.
// Latency: ROM model answers one CLK after rom_addr, stable through the fetch.
// Backpressure: none; lrclk free-runs with a 16-CLK period.
module tb_sfx_arbiter;
    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        lrclk = 1'b0;
    logic [3:0]  req = 4'b0000;
    logic [7:0]  rom_q = 8'h00;
    logic [14:0] rom_addr;
    logic [7:0]  sample_out;
    logic        sample_strobe;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [14:0] addr;
        logic [7:0]  data;
        bit          opt;
    } exp_t;
    exp_t exp_q[$];

    sfx_arbiter_if avl();

    sfx_arbiter dut (
        .CLK(CLK),
        .RESET(RESET),
        .lrclk(lrclk),
        .req(req),
        .avl(avl),
        .rom_addr(rom_addr),
        .rom_q(rom_q),
        .sample_out(sample_out),
        .sample_strobe(sample_strobe),
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] rom_fn(input logic [14:0] a);
        return a[7:0] ^ {1'b0, a[14:8]} ^ 8'hA5;
    endfunction

    always @(posedge CLK) rom_q <= rom_fn(rom_addr);

    initial begin
        forever begin
            repeat (8) @(negedge CLK);
            lrclk = ~lrclk;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every strobe must match the head entry; optional entries may be skipped
    always @(negedge CLK) begin : mon
        exp_t e;
        if (sample_strobe) begin
            while (exp_q.size() > 0 && exp_q[0].opt && exp_q[0].addr != rom_addr)
                e = exp_q.pop_front();
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected: sample %02h at addr %04h, required no strobe",
                         sample_out, rom_addr);
            end else begin
                e = exp_q.pop_front();
                if (sample_out !== e.data || rom_addr !== e.addr) begin
                    errors++;
                    $display("FAIL strobe_data: got sample %02h addr %04h, required sample %02h addr %04h",
                             sample_out, rom_addr, e.data, e.addr);
                end
            end
        end
    end

    task automatic push(input logic [14:0] a, input bit muted, input bit opt);
        exp_t e;
        e.addr = a;
        e.data = muted ? 8'h00 : rom_fn(a);
        e.opt  = opt;
        exp_q.push_back(e);
    endtask

    task automatic avl_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge CLK);
        avl.AVL_CS = 1'b1; avl.AVL_WRITE = 1'b1;
        avl.AVL_ADDR = a; avl.AVL_WRITEDATA = d; avl.AVL_BYTE_EN = be;
        @(negedge CLK);
        avl.AVL_CS = 1'b0; avl.AVL_WRITE = 1'b0;
    endtask

    task automatic avl_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge CLK);
        avl.AVL_CS = 1'b1; avl.AVL_READ = 1'b1; avl.AVL_ADDR = a;
        @(negedge CLK);
        avl.AVL_CS = 1'b0; avl.AVL_READ = 1'b0;
        d = avl.AVL_READDATA;
    endtask

    task automatic wait_q(input int n, input int limit, output bit ok);
        int i = 0;
        while (exp_q.size() > n && i < limit) begin
            @(negedge CLK);
            i++;
        end
        ok = (exp_q.size() <= n);
    endtask

    task automatic wait_idle(input int limit, output bit ok);
        int i = 0;
        while (busy !== 1'b0 && i < limit) begin
            @(negedge CLK);
            i++;
        end
        ok = (busy === 1'b0);
    endtask

    task automatic pulse_req(input logic [3:0] m);
        @(negedge CLK);
        req = m;
        repeat (2) @(negedge CLK);
        req = 4'b0000;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        RESET = 1'b0;
        repeat (3) @(negedge CLK);
        checks++; if (sample_out !== 8'h00) begin errors++; $display("FAIL rst_sample_out: got %02h, required 00", sample_out); end
        checks++; if (sample_strobe !== 1'b0) begin errors++; $display("FAIL rst_strobe: got %b, required 0", sample_strobe); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
        checks++; if (rom_addr !== 15'h0000) begin errors++; $display("FAIL rst_rom_addr: got %04h, required 0000", rom_addr); end
        checks++; if (avl.AVL_READDATA !== 32'h0) begin errors++; $display("FAIL rst_readdata: got %08h, required 0", avl.AVL_READDATA); end
        RESET = 1'b1;
        avl_read(4'd0, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_ctrl: got %08h, required 0", d); end
        avl_read(4'd2, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_status: got %08h, required 0", d); end
        avl_read(4'd11, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_len3: got %08h, required 0", d); end
    endtask

    task automatic test_regs();
        logic [31:0] d;
        avl_write(4'd0, 32'hFFFF_F10F, 4'hF);
        avl_read(4'd0, d);
        checks++; if (d !== 32'h0000_010F) begin errors++; $display("FAIL reg_ctrl: got %08h, required 0000010f", d); end
        avl_write(4'd6, 32'h0000_FFFF, 4'b0001);
        avl_read(4'd6, d);
        checks++; if (d !== 32'h0000_00FF) begin errors++; $display("FAIL reg_base1_byte0: got %08h, required 000000ff", d); end
        avl_write(4'd6, 32'h0000_1234, 4'b0010);
        avl_read(4'd6, d);
        checks++; if (d !== 32'h0000_12FF) begin errors++; $display("FAIL reg_base1_byte1: got %08h, required 000012ff", d); end
        avl_write(4'd11, 32'hFFFF_FFFF, 4'hF);
        avl_read(4'd11, d);
        checks++; if (d !== 32'h0000_7FFF) begin errors++; $display("FAIL reg_len3: got %08h, required 00007fff", d); end
        avl_write(4'd3, 32'hFFFF_FFFF, 4'hF);
        avl_read(4'd3, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reg_unmapped: got %08h, required 0", d); end
        avl_write(4'd0, 32'h0, 4'hF);
    endtask

    task automatic test_single_play();
        bit ok;
        avl_write(4'd4, 32'h0100, 4'hF);
        avl_write(4'd5, 32'd3, 4'hF);
        avl_write(4'd0, 32'h1, 4'hF);
        for (int k = 0; k < 3; k++) push(15'h0100 + 15'(k), 1'b0, 1'b0);
        pulse_req(4'b0001);
        wait_q(0, 400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_drain: %0d samples missing, required 0", exp_q.size()); end
        wait_idle(40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_busy: got %b, required 0", busy); end
        checks++; if (sample_out !== 8'h00) begin errors++; $display("FAIL single_sample_out: got %02h, required 00", sample_out); end
    endtask

    task automatic test_priority();
        bit ok;
        logic [31:0] d;
        avl_write(4'd6, 32'h0200, 4'hF);
        avl_write(4'd7, 32'd2, 4'hF);
        avl_write(4'd8, 32'h0300, 4'hF);
        avl_write(4'd9, 32'd2, 4'hF);
        avl_write(4'd0, 32'h6, 4'hF);
        push(15'h0200, 1'b0, 1'b0); push(15'h0201, 1'b0, 1'b0);
        push(15'h0300, 1'b0, 1'b0); push(15'h0301, 1'b0, 1'b0);
        pulse_req(4'b0110);
        wait_q(3, 200, ok);
        avl_read(4'd2, d);
        checks++; if (!ok || d[6:0] !== 7'b101_0100) begin errors++; $display("FAIL prio_status_ch1: got %02h, required 54", d[6:0]); end
        wait_q(1, 300, ok);
        avl_read(4'd2, d);
        checks++; if (!ok || d[6:4] !== 3'b110) begin errors++; $display("FAIL prio_status_ch2: got %01h, required 6", d[6:4]); end
        wait_q(0, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL prio_drain: %0d samples missing, required 0", exp_q.size()); end
        wait_idle(40, ok);
    endtask

    task automatic test_preempt();
        bit ok;
        logic [31:0] d;
        avl_write(4'd10, 32'h0400, 4'hF);
        avl_write(4'd11, 32'd100, 4'hF);
        avl_write(4'd4, 32'h0500, 4'hF);
        avl_write(4'd5, 32'd3, 4'hF);
        avl_write(4'd0, 32'h9, 4'hF);
        for (int k = 0; k < 10; k++) push(15'h0400 + 15'(k), 1'b0, 1'b0);
        pulse_req(4'b1000);
        wait_q(0, 400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL preempt_ch3: %0d samples missing, required 0", exp_q.size()); end
        push(15'h040A, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) push(15'h0500 + 15'(k), 1'b0, 1'b0);
        pulse_req(4'b0001);
        wait_q(0, 400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL preempt_ch0: %0d samples missing, required 0", exp_q.size()); end
        repeat (100) @(negedge CLK);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL preempt_no_resume: busy %b, required 0", busy); end
        avl_read(4'd2, d);
        checks++; if (d[5:0] !== 6'h00) begin errors++; $display("FAIL preempt_status: got %02h, required 00", d[5:0]); end
    endtask

    task automatic test_len_zero();
        bit saw_busy = 1'b0;
        logic [31:0] d;
        avl_write(4'd0, 32'h0, 4'hF);
        avl_write(4'd9, 32'h0, 4'hF);
        avl_write(4'd1, 32'h4, 4'hF);
        for (int k = 0; k < 30; k++) begin
            @(negedge CLK);
            if (busy !== 1'b0) saw_busy = 1'b1;
        end
        checks++; if (saw_busy) begin errors++; $display("FAIL len0_busy: got 1, required 0"); end
        avl_read(4'd2, d);
        checks++; if (d[3:0] !== 4'h0) begin errors++; $display("FAIL len0_pending: got %01h, required 0", d[3:0]); end
        checks++; if (sample_out !== 8'h00) begin errors++; $display("FAIL len0_sample_out: got %02h, required 00", sample_out); end
    endtask

    task automatic test_enable_off();
        logic [31:0] d;
        avl_write(4'd0, 32'h0, 4'hF);
        pulse_req(4'b1111);
        repeat (4) @(negedge CLK);
        avl_read(4'd2, d);
        checks++; if (d[3:0] !== 4'h0) begin errors++; $display("FAIL enoff_pending: got %01h, required 0", d[3:0]); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL enoff_busy: got %b, required 0", busy); end
    endtask

    task automatic test_mute();
        bit ok;
        avl_write(4'd6, 32'h0600, 4'hF);
        avl_write(4'd7, 32'd4, 4'hF);
        avl_write(4'd0, 32'h2, 4'hF);
        push(15'h0600, 1'b0, 1'b0);
        for (int k = 1; k < 4; k++) push(15'h0600 + 15'(k), 1'b1, 1'b0);
        avl_write(4'd1, 32'h2, 4'hF);
        wait_q(3, 200, ok);
        avl_write(4'd0, 32'h102, 4'hF);
        wait_q(0, 300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mute_drain: %0d samples missing, required 0", exp_q.size()); end
        wait_idle(40, ok);
        avl_write(4'd0, 32'h0, 4'hF);
    endtask

    task automatic test_reset_mid();
        bit ok;
        avl_write(4'd4, 32'h0700, 4'hF);
        avl_write(4'd5, 32'd10, 4'hF);
        avl_write(4'd0, 32'h1, 4'hF);
        push(15'h0700, 1'b0, 1'b0); push(15'h0701, 1'b0, 1'b0);
        pulse_req(4'b0001);
        wait_q(0, 300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL midrst_pre: %0d samples missing, required 0", exp_q.size()); end
        RESET = 1'b0;
        @(negedge CLK);
        checks++; if ({sample_out, sample_strobe, busy} !== 10'h0) begin errors++; $display("FAIL midrst_outputs: got %02h/%b/%b, required 00/0/0", sample_out, sample_strobe, busy); end
        checks++; if (rom_addr !== 15'h0 || avl.AVL_READDATA !== 32'h0) begin errors++; $display("FAIL midrst_addr_rd: got %04h/%08h, required 0/0", rom_addr, avl.AVL_READDATA); end
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        repeat (100) @(negedge CLK);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_after: busy %b, required 0", busy); end
    endtask

    initial begin
        avl.AVL_CS = 1'b0; avl.AVL_READ = 1'b0; avl.AVL_WRITE = 1'b0;
        avl.AVL_ADDR = 4'd0; avl.AVL_WRITEDATA = 32'd0; avl.AVL_BYTE_EN = 4'h0;
        test_reset();
        test_regs();
        test_single_play();
        test_priority();
        test_preempt();
        test_len_zero();
        test_enable_off();
        test_mute();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_queue: %0d samples outstanding, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
